axi_lite_master: RTL
====================

Name: axi_lite_master

Overview:
- Single-outstanding AXI-lite master that sits directly upstream of axi_lite_slave and drives all five of its channels.
- Converts a simple valid/ready command port (read or write, address, data) into AXI-lite transactions.
- Returns each completion (read data plus response code) on a valid/ready response port.
- Replaces the random/always-fire stimulus generators in benches and is the bus front-end for any local controller.

Parameters:
- DATA_WD, 8, data width of wdata/rdata/cmd_wdata/rsp_rdata.
- ADDR_WD, 8, address width of awaddr/araddr/cmd_addr.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
- cmd_wr  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_WD  transaction address.
- cmd_wdata  input  DATA_WD  write data (ignored for reads).
- rsp_valid  output  1  completion available.
- rsp_ready  input  1  completion consumed when rsp_valid && rsp_ready.
- rsp_wr  output  1  completion belongs to a write.
- rsp_rdata  output  DATA_WD  read data; 0 for writes.
- rsp_resp  output  2  bresp or rresp of the completed transaction.
- awaddr/awvalid (out ADDR_WD/1), awready (in 1): write-address channel.
- wdata/wvalid (out DATA_WD/1), wready (in 1): write-data channel.
- bresp (in 2), bvalid (in 1), bready (out 1): write-response channel.
- araddr/arvalid (out ADDR_WD/1), arready (in 1): read-address channel.
- rdata (in DATA_WD), rresp (in 2), rvalid (in 1), rready (out 1): read-data channel.

Behaviour:
- Reset (rst high at a clock edge): state IDLE; all valid/ready outputs 0 except cmd_ready = 1; awaddr, araddr, wdata, rsp_rdata, rsp_resp and rsp_wr are 0.
- Reset mid-transaction aborts immediately: valids drop the cycle after rst is sampled, and no rsp is produced.
- States: IDLE, WADDR, WRESP, RADDR, RDATA, RSP.
- cmd_ready is 1 only in IDLE and is registered, so at most one transaction is outstanding.
- Write path:
  - IDLE + cmd fire with cmd_wr = 1: latch addr/data; next cycle awvalid = wvalid = 1; go to WADDR.
  - WADDR tracks AW and W independently. awvalid drops the cycle after awvalid && awready; wvalid drops the cycle after wvalid && wready. Either may complete first, or both in the same cycle.
  - Once both have fired, go to WRESP with bready = 1.
  - A valid, once raised, never drops before its handshake; awaddr/wdata stay stable while their valid is high.
  - In WRESP, on bvalid && bready: capture bresp into rsp_resp, set rsp_wr = 1 and rsp_rdata = 0, drop bready, go to RSP.
- Read path:
  - IDLE + cmd fire with cmd_wr = 0: next cycle arvalid = 1 with araddr latched; go to RADDR.
  - In RADDR, arvalid drops after arvalid && arready; go to RDATA with rready = 1.
  - In RDATA, on rvalid && rready: capture rdata/rresp, set rsp_wr = 0, drop rready, go to RSP.
- RSP state:
  - rsp_valid = 1; rsp_* held stable until rsp_valid && rsp_ready.
  - After that handshake: return to IDLE and set cmd_ready = 1 on the next cycle.
  - rsp_ready may be held high permanently.
- Minimum latency, with the slave always ready and responding one cycle after the address/data fire:
  - cmd fire at cycle N; AW/W valid at N+1; fire at N+1; B at N+2; rsp_valid at N+3.
  - The read path has the same latency.
- Response codes pass through unmodified; non-OKAY responses do not stop the block.
- Addresses and data are not modified.
- Responses arriving outside their state (bvalid when not in WRESP, rvalid when not in RDATA) are ignored, because the matching ready is low.

Optional Feature:
- Macro AXIL_MASTER_ERRCNT_EN.
- Defined:
  - Adds output err_cnt (8 bits).
  - err_cnt increments by 1 on every B or R handshake whose resp != 2'b00.
  - Saturates at 8'hFF and clears on rst.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Write, slave always ready, bresp = 0: cmd write addr 8'h05, data 8'hA5 -> awaddr = 05 and wdata = A5 valid for 1 cycle each; rsp_valid at N+3 with rsp_wr = 1, rsp_resp = 00, rsp_rdata = 00.
- Read after that write: cmd read addr 8'h05, slave returns rdata 8'hA5 -> arvalid for 1 cycle; rsp_rdata = A5, rsp_wr = 0, rsp_resp = 00.
- Skewed write handshake: wready high 3 cycles before awready -> wvalid drops after W fire while awvalid stays high, stable with awaddr unchanged; exactly one rsp.
- Backpressure: rsp_ready low for 5 cycles -> rsp_valid and rsp_* held; cmd_ready stays 0; on release, cmd_ready = 1 the next cycle.
- Error response: slave returns bresp = 2'b10 -> rsp_resp = 10; with AXIL_MASTER_ERRCNT_EN, err_cnt goes 0 -> 1. 300 error responses -> err_cnt = FF.
- Reset mid-read: assert rst while in RDATA -> next cycle rready = 0, rsp_valid = 0, cmd_ready = 1; the next command runs normally.

Source files
------------

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-lite master: valid/ready command in, response out.
// Optional error counter output enabled by define AXIL_MASTER_ERRCNT_EN.
module axi_lite_master #(
  parameter int DATA_WD = 8,
  parameter int ADDR_WD = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_wr,
  input  logic [ADDR_WD-1:0] cmd_addr,
  input  logic [DATA_WD-1:0] cmd_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_wr,
  output logic [DATA_WD-1:0] rsp_rdata,
  output logic [1:0]         rsp_resp,
  output logic [ADDR_WD-1:0] awaddr,
  output logic               awvalid,
  input  logic               awready,
  output logic [DATA_WD-1:0] wdata,
  output logic               wvalid,
  input  logic               wready,
  input  logic [1:0]         bresp,
  input  logic               bvalid,
  output logic               bready,
  output logic [ADDR_WD-1:0] araddr,
  output logic               arvalid,
  input  logic               arready,
  input  logic [DATA_WD-1:0] rdata,
  input  logic [1:0]         rresp,
  input  logic               rvalid,
  output logic               rready
`ifdef AXIL_MASTER_ERRCNT_EN
  ,
  output logic [7:0]         err_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    WADDR,
    WRESP,
    RADDR,
    RDATA,
    RSP
  } state_t;

  state_t               state_q;
  logic                 cmd_ready_q;
  logic                 rsp_valid_q;
  logic                 rsp_wr_q;
  logic [DATA_WD-1:0]   rsp_rdata_q;
  logic [1:0]           rsp_resp_q;
  logic [ADDR_WD-1:0]   awaddr_q;
  logic                 awvalid_q;
  logic [DATA_WD-1:0]   wdata_q;
  logic                 wvalid_q;
  logic                 bready_q;
  logic [ADDR_WD-1:0]   araddr_q;
  logic                 arvalid_q;
  logic                 rready_q;

  logic aw_pend;
  logic w_pend;
  logic b_fire;
  logic r_fire;

  // A channel is still pending while its valid is up and not accepted.
  assign aw_pend = awvalid_q && !awready;
  assign w_pend  = wvalid_q && !wready;
  assign b_fire  = bready_q && bvalid;
  assign r_fire  = rready_q && rvalid;

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_wr    = rsp_wr_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign awaddr    = awaddr_q;
  assign awvalid   = awvalid_q;
  assign wdata     = wdata_q;
  assign wvalid    = wvalid_q;
  assign bready    = bready_q;
  assign araddr    = araddr_q;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;

  // Transaction FSM with all bus and response outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_wr_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
      awaddr_q    <= '0;
      awvalid_q   <= 1'b0;
      wdata_q     <= '0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready_q <= 1'b0;
            if (cmd_wr) begin
              awaddr_q  <= cmd_addr;
              wdata_q   <= cmd_wdata;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WADDR;
            end else begin
              araddr_q  <= cmd_addr;
              arvalid_q <= 1'b1;
              state_q   <= RADDR;
            end
          end
        end
        WADDR: begin
          if (awvalid_q && awready) awvalid_q <= 1'b0;
          if (wvalid_q && wready)   wvalid_q  <= 1'b0;
          if (!aw_pend && !w_pend) begin
            bready_q <= 1'b1;
            state_q  <= WRESP;
          end
        end
        WRESP: begin
          if (b_fire) begin
            bready_q    <= 1'b0;
            rsp_resp_q  <= bresp;
            rsp_wr_q    <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= RSP;
          end
        end
        RADDR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RDATA;
          end
        end
        RDATA: begin
          if (r_fire) begin
            rready_q    <= 1'b0;
            rsp_resp_q  <= rresp;
            rsp_wr_q    <= 1'b0;
            rsp_rdata_q <= rdata;
            rsp_valid_q <= 1'b1;
            state_q     <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef AXIL_MASTER_ERRCNT_EN
  logic [7:0] err_cnt_q;
  logic       err_hit;

  assign err_hit = (b_fire && (bresp != 2'b00)) ||
                   (r_fire && (rresp != 2'b00));
  assign err_cnt = err_cnt_q;

  // Saturating count of non-OKAY B/R handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= 8'h00;
    end else if (err_hit && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'h01;
    end
  end
`endif

endmodule
